flash_addr_ctrl: RTL and testbench
==================================

// Module: flash_addr_ctrl
// PURPOSE
//  Sequences the flash word address consumed by FlashReader during audio playback.
//  - Advances one word per address_change pulse from FlashReader.
//  - Applies keyboard direction, pause and restart commands.
//  - Handles song-boundary wrap or halt; sits between keyboard decoder, FlashReader and flash.
// PARAMETERS
//  ADDR_W      23          flash word-address width
//  START_ADDR  23'h000000  first word of song (inclusive)
//  END_ADDR    23'h07FFFF  last word of song (inclusive); must be > START_ADDR
// PORTS
//  clk             in   1       system clock; all logic on rising edge
//  reset_n         in   1       synchronous reset, active-low
//  kybrd_dir       in   1       0 = forward, 1 = backward (level)
//  kybrd_pause     in   1       1 = hold address, ignore address_change (level)
//  kybrd_restart   in   1       1-cycle pulse: jump to song start for current direction
//  address_change  in   1       1-cycle pulse from FlashReader: current word consumed
//  flsh_address    out  ADDR_W  word address presented to flash
//  end_of_song     out  1       1-cycle pulse: boundary reached on an advance
//  ctrl_state      out  2       current state (debug); encoding from package
// BEHAVIOUR
//  Reset (reset_n == 0 at a clk edge)
//  - flsh_address = START_ADDR, end_of_song = 0, state = RUN.
//  States: RUN, PAUSED, DONE.
//  - RUN -> PAUSED when kybrd_pause == 1.
//  - PAUSED -> RUN when kybrd_pause == 0.
//  - RUN -> DONE on boundary advance, only when ADDR_LOOP_EN is undefined.
//  - DONE -> RUN on kybrd_restart; DONE holds flsh_address.
//  Advance: address_change sampled in RUN, and only in RUN (ignored in PAUSED and DONE).
//  - fwd: addr == END_ADDR ? boundary : addr + 1.
//  - bwd: addr == START_ADDR ? boundary : addr - 1.
//  - kybrd_dir sampled in the advance cycle; a direction change never moves the address by itself.
//  Latency
//  - flsh_address registered; updates on the edge following the sampled pulse.
//  - end_of_song asserted in the same cycle the boundary address appears.
//  Restart
//  - Loads START_ADDR (dir = 0) or END_ADDR (dir = 1) on the next edge.
//  - Allowed in any state; restart while PAUSED loads the address and stays PAUSED.
//  - Restart has priority over a simultaneous address_change; that advance is dropped.
//  Pause
//  - If pause and address_change arrive in the same cycle, pause wins and the advance is dropped.
//  Reset mid-operation: reset_n dominates all inputs and returns to reset values.
//  Width
//  - addr arithmetic ADDR_W bits unsigned; boundaries are compared, never rely on overflow.
//  - Address is never outside [START_ADDR, END_ADDR].
// CONFIGURATION
//  ADDR_LOOP_EN defined
//  - At boundary, fwd wraps END->START and bwd wraps START->END.
//  - end_of_song pulses; state stays RUN.
//  ADDR_LOOP_EN undefined
//  - At boundary, the address holds at END (fwd) or START (bwd).
//  - end_of_song pulses once; state -> DONE.
// STRUCTURE
//  flash_ctrl_pkg holds:
//  - typedef enum logic[1:0] ctrl_state_t {RUN, PAUSED, DONE}.
//  - typedef enum logic dir_t {DIR_FWD, DIR_BWD}.
//  Sub-module addr_stepper (combinational)
//  - Inputs: addr, dir.
//  - Outputs: next_addr, at_boundary.
//  - Parameters shared with top (ADDR_W, START_ADDR, END_ADDR).
// TESTING  (bench overrides START_ADDR = 4, END_ADDR = 7)
//  - Reset, then 3 fwd address_change pulses -> flsh_address 4,5,6,7; end_of_song stays 0.
//  - At 7, fwd pulse -> LOOP_EN: addr 4 + end_of_song 1 cycle; else addr 7, state DONE.
//  - dir = 1 at addr 5, 2 pulses -> 4 then boundary (LOOP_EN: 7; else 4 + DONE).
//  - pause = 1, 3 pulses -> addr unchanged, state PAUSED; release + pulse -> addr + 1.
//  - restart and address_change same cycle at addr 6, dir = 0 -> addr 4, no advance.
//  - reset_n low mid-RUN at addr 6 -> next edge addr 4, RUN, end_of_song 0.

Source files
------------

// File: rtl/flash_ctrl_pkg.sv
// Shared types for the flash address sequencer: controller states and playback direction.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package flash_ctrl_pkg;

  // Controller state, also exported on the ctrl_state debug port.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    DONE   = 2'd2
  } ctrl_state_t;

  // Playback direction as decoded from the keyboard level.
  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_BWD = 1'b1
  } dir_t;

endpackage

// File: rtl/flash_addr_ctrl_stepper.sv
// Computes the neighbouring song word in the requested direction and flags the song edge.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is used.
//
// Ports:
//   addr        current word address (always within [START_ADDR, END_ADDR])
//   dir         DIR_FWD / DIR_BWD
//   next_addr   addr+1 / addr-1, or the opposite song edge when at_boundary
//   at_boundary addr sits on the last word in the travel direction
module addr_stepper
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_W     = 23,
  parameter logic [ADDR_W-1:0]     START_ADDR = ADDR_W'(23'h000000),
  parameter logic [ADDR_W-1:0]     END_ADDR   = ADDR_W'(23'h07FFFF)
) (
  input  logic [ADDR_W-1:0] addr,
  input  dir_t              dir,
  output logic [ADDR_W-1:0] next_addr,
  output logic              at_boundary
);

  always_comb begin
    next_addr   = addr;
    at_boundary = 1'b0;
    if (dir == DIR_FWD) begin
      // Compare against the edge instead of relying on wrap-around of the adder,
      // so a song ending below 2**ADDR_W-1 still stops at its own last word.
      if (addr == END_ADDR) begin
        at_boundary = 1'b1;
        next_addr   = START_ADDR;
      end else begin
        next_addr = addr + ADDR_W'(1);
      end
    end else begin
      if (addr == START_ADDR) begin
        at_boundary = 1'b1;
        next_addr   = END_ADDR;
      end else begin
        next_addr = addr - ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/flash_addr_ctrl.sv
// Sequences the flash word address for audio playback: one word per address_change, with keyboard direction/pause/restart.
// Latency: flsh_address and end_of_song update on the clock edge after the sampled pulse.
// Backpressure: none; advances arriving while paused, done, or alongside a restart are dropped.
//
// Ports:
//   clk, reset_n     clock and synchronous active-low reset
//   kybrd_dir        direction level (0 fwd, 1 bwd), sampled on the advance/restart cycle
//   kybrd_pause      pause level; holds the address while high
//   kybrd_restart    pulse; loads the song start for the current direction
//   address_change   pulse from FlashReader; current word consumed
//   flsh_address     registered word address presented to flash
//   end_of_song      one-cycle pulse coincident with the boundary address
//   ctrl_state       current ctrl_state_t (debug)
// Build option: define ADDR_LOOP_EN to wrap at the song edges instead of halting in DONE.
module flash_addr_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_W     = 23,
  parameter logic [ADDR_W-1:0]     START_ADDR = ADDR_W'(23'h000000),
  parameter logic [ADDR_W-1:0]     END_ADDR   = ADDR_W'(23'h07FFFF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              kybrd_dir,
  input  logic              kybrd_pause,
  input  logic              kybrd_restart,
  input  logic              address_change,
  output logic [ADDR_W-1:0] flsh_address,
  output logic              end_of_song,
  output logic [1:0]        ctrl_state
);

  ctrl_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              eos_q, eos_d;

  dir_t              dir;
  logic [ADDR_W-1:0] step_addr;
  logic              at_boundary;
  logic [ADDR_W-1:0] restart_addr;

  assign dir          = dir_t'(kybrd_dir);
  // Backward playback starts from the last word of the song.
  assign restart_addr = (dir == DIR_BWD) ? END_ADDR : START_ADDR;

  addr_stepper #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_stepper (
    .addr        (addr_q),
    .dir         (dir),
    .next_addr   (step_addr),
    .at_boundary (at_boundary)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    eos_d   = 1'b0;

    unique case (state_q)
      RUN: begin
        // Restart outranks a same-cycle advance; pause suppresses the advance too.
        if (kybrd_restart) begin
          addr_d = restart_addr;
        end else if (address_change && !kybrd_pause) begin
          if (at_boundary) begin
            eos_d = 1'b1;
`ifdef ADDR_LOOP_EN
            addr_d = step_addr;
`else
            state_d = DONE;
`endif
          end else begin
            addr_d = step_addr;
          end
        end
        if (kybrd_pause) begin
          state_d = PAUSED;
        end
      end

      PAUSED: begin
        // A restart while paused repositions the song but keeps it paused.
        if (kybrd_restart) begin
          addr_d = restart_addr;
        end
        if (!kybrd_pause) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (kybrd_restart) begin
          addr_d  = restart_addr;
          state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
        addr_d  = START_ADDR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      addr_q  <= START_ADDR;
      eos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      eos_q   <= eos_d;
    end
  end

  assign flsh_address = addr_q;
  assign end_of_song  = eos_q;
  assign ctrl_state   = state_q;

endmodule

// File: tb/tb_flash_addr_ctrl.sv
module tb_flash_addr_ctrl;
  import flash_ctrl_pkg::*;

  localparam int unsigned AW = 23;
  localparam int S_ADDR = 4;
  localparam int E_ADDR = 7;
`ifdef ADDR_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          kybrd_dir = 1'b0;
  logic          kybrd_pause = 1'b0;
  logic          kybrd_restart = 1'b0;
  logic          address_change = 1'b0;
  logic [AW-1:0] flsh_address;
  logic          end_of_song;
  logic [1:0]    ctrl_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flash_addr_ctrl #(
    .ADDR_W     (AW),
    .START_ADDR (AW'(S_ADDR)),
    .END_ADDR   (AW'(E_ADDR))
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .kybrd_dir      (kybrd_dir),
    .kybrd_pause    (kybrd_pause),
    .kybrd_restart  (kybrd_restart),
    .address_change (address_change),
    .flsh_address   (flsh_address),
    .end_of_song    (end_of_song),
    .ctrl_state     (ctrl_state)
  );

  typedef struct {
    bit         restart;
    bit         chg;
    bit         dir;
    bit         pause;
    int         exp_addr;
    bit         exp_eos;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit c, input bit d, input bit p,
                     input int ea, input bit ee, input ctrl_state_t es);
    vec_t v;
    v.restart = r; v.chg = c; v.dir = d; v.pause = p;
    v.exp_addr = ea; v.exp_eos = ee; v.exp_st = es;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int ea, input bit ee, input logic [1:0] es);
    check({tag, ".addr"},  {9'b0, flsh_address}, ea);
    check({tag, ".eos"},   {31'b0, end_of_song}, {31'b0, ee});
    check({tag, ".state"}, {30'b0, ctrl_state},  {30'b0, es});
  endtask

  // One clock cycle: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge.
  task automatic cycle(input bit rn, input bit r, input bit c, input bit d, input bit p);
    @(negedge clk);
    reset_n = rn; kybrd_restart = r; address_change = c; kybrd_dir = d; kybrd_pause = p;
    @(posedge clk);
    #1;
  endtask

  // Reference model: song position kept as an offset into a ring of N words.
  int          m_addr;
  ctrl_state_t m_st;
  bit          m_eos;

  task automatic model_step(input bit rn, input bit r, input bit c, input bit d, input bit p);
    int n, off;
    bit adv;
    n = E_ADDR - S_ADDR + 1;
    if (!rn) begin
      m_addr = S_ADDR; m_st = RUN; m_eos = 1'b0;
      return;
    end
    m_eos = 1'b0;
    adv = (m_st == RUN) && c && !p && !r;
    off = m_addr - S_ADDR;
    if (r) begin
      m_addr = d ? E_ADDR : S_ADDR;
    end else if (adv) begin
      if ((!d && off == n - 1) || (d && off == 0)) begin
        m_eos = 1'b1;
        if (LOOP) m_addr = S_ADDR + (d ? (off - 1 + n) % n : (off + 1) % n);
      end else begin
        m_addr = m_addr + (d ? -1 : 1);
      end
    end
    case (m_st)
      RUN:     if (p) m_st = PAUSED; else if (adv && m_eos && !LOOP) m_st = DONE;
      PAUSED:  if (!p) m_st = RUN;
      default: if (r) m_st = RUN;
    endcase
  endtask

  initial begin
    // Directed table, starting right after reset at START.
    add(0,1,0,0, 5, 0, RUN);
    add(0,1,0,0, 6, 0, RUN);
    add(0,1,0,0, 7, 0, RUN);
    add(0,1,0,0, LOOP ? 4 : 7, 1, LOOP ? RUN : DONE);
    add(0,0,0,0, LOOP ? 4 : 7, 0, LOOP ? RUN : DONE);
    add(0,1,0,0, LOOP ? 5 : 7, 0, LOOP ? RUN : DONE);
    add(1,0,0,0, 4, 0, RUN);
    add(0,1,0,0, 5, 0, RUN);
    add(0,1,1,0, 4, 0, RUN);
    add(0,1,1,0, LOOP ? 7 : 4, 1, LOOP ? RUN : DONE);
    add(0,0,1,0, LOOP ? 7 : 4, 0, LOOP ? RUN : DONE);
    add(1,0,1,0, 7, 0, RUN);
    add(0,1,1,0, 6, 0, RUN);
    add(0,0,0,0, 6, 0, RUN);
    add(0,1,0,1, 6, 0, PAUSED);
    add(0,1,0,1, 6, 0, PAUSED);
    add(0,1,0,1, 6, 0, PAUSED);
    add(0,0,0,0, 6, 0, RUN);
    add(0,1,0,0, 7, 0, RUN);
    add(0,0,0,1, 7, 0, PAUSED);
    add(1,1,0,1, 4, 0, PAUSED);
    add(0,0,0,0, 4, 0, RUN);
    add(0,1,0,0, 5, 0, RUN);
    add(0,1,0,0, 6, 0, RUN);
    add(1,1,0,0, 4, 0, RUN);
    add(0,1,0,0, 5, 0, RUN);
    add(0,1,0,0, 6, 0, RUN);

    // Reset state.
    cycle(0,0,0,0,0);
    cycle(0,0,1,1,1);
    check_all("reset", S_ADDR, 1'b0, RUN);

    foreach (vecs[i]) begin
      cycle(1, vecs[i].restart, vecs[i].chg, vecs[i].dir, vecs[i].pause);
      check_all($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_eos, vecs[i].exp_st);
    end

    // Reset mid-run at address 6 beats a simultaneous advance.
    cycle(0,0,1,0,0);
    check_all("mid_reset", S_ADDR, 1'b0, RUN);

    // end_of_song must be a single-cycle pulse even if advances keep coming (loop) or stop (halt).
    cycle(1,1,0,1,0);
    check_all("bwd_restart", E_ADDR, 1'b0, RUN);
    cycle(1,0,1,0,0);
    check_all("fwd_edge", LOOP ? S_ADDR : E_ADDR, 1'b1, LOOP ? RUN : DONE);
    cycle(1,0,1,0,0);
    check_all("fwd_after_edge", LOOP ? S_ADDR + 1 : E_ADDR, 1'b0, LOOP ? RUN : DONE);

    // Randomized run against the reference model.
    cycle(0,0,0,0,0);
    model_step(0,0,0,0,0);
    for (int k = 0; k < 3000; k++) begin
      bit rn, r, c, d, p;
      rn = ($urandom_range(0, 99) != 0);
      r  = ($urandom_range(0, 19) == 0);
      c  = ($urandom_range(0, 1) == 1);
      d  = ($urandom_range(0, 3) == 0) ? ~kybrd_dir : kybrd_dir;
      p  = ($urandom_range(0, 7) == 0) ? ~kybrd_pause : kybrd_pause;
      model_step(rn, r, c, d, p);
      cycle(rn, r, c, d, p);
      check_all($sformatf("rnd%0d", k), m_addr, m_eos, m_st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
